fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one 16-deep x 8-bit FIFO write port between NREQ producers. Each producer offers data with a valid/ready handshake. The arbiter grants the port to one producer for a bounded burst and drives the FIFO's w_en/data_in. It honours the FIFO full flag so no write is ever issued while the FIFO is full.

Parameters:
NREQ, 4, number of requesting producers (1..16)
DW, 8, data width; matches FIFO data_in
MAX_BURST, 4, max beats per grant before forced re-arbitration (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NREQ  producer i has a beat on req_data slice i
req_data  input  NREQ*DW  packed producer data; slice i = bits [i*DW +: DW]
req_ready  output  NREQ  beat from producer i accepted this cycle
fifo_full  input  1  FIFO full flag
fifo_w_en  output  1  FIFO write enable
fifo_data  output  DW  FIFO write data
gnt  output  NREQ  one-hot current owner; 0 when idle

Behaviour:
- Interface: one clock; reset is synchronous and active-high; port names clk and rst.
- Reset (rst=1 at a rising edge):
  - state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
  - gnt=0, req_ready=0, fifo_w_en=0, fifo_data=0 after the edge.
- Registered state: state {IDLE, BURST}, owner[$clog2(NREQ) min 1], rr_ptr (same width), beat_cnt[$clog2(MAX_BURST) min 1].
- IDLE:
  - gnt=0, no writes.
  - If any req_valid, choose the first valid index searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - Next state BURST, owner=winner, beat_cnt=0.
  - Arbitration costs exactly 1 cycle.
- BURST:
  - gnt = one-hot(owner).
  - Beat transfer (combinational, same cycle) = req_valid[owner] & !fifo_full.
  - On a transfer: fifo_w_en=1, req_ready[owner]=1, fifo_data = req_data slice owner.
  - Otherwise fifo_w_en=0, fifo_data=0, all req_ready=0.
- Leave BURST (next state IDLE, rr_ptr = owner+1 mod NREQ) when either:
  - a transfer occurs with beat_cnt==MAX_BURST-1 (burst complete); or
  - req_valid[owner]==0 (producer released, no transfer that cycle).
  - Otherwise beat_cnt increments on each transfer and holds on a stall.
- fifo_full=1 in BURST stalls: no write, no count, ownership kept, no timeout.
- Non-owners' req_ready is always 0; their data is ignored.
- Fairness: with all NREQ continuously valid and FIFO never full, grant order is 0,1,...,NREQ-1,0. Each producer gets MAX_BURST beats, then 1 idle arbitration cycle.
- Boundaries:
  - NREQ=1: rr_ptr stays 0.
  - MAX_BURST=1: one beat per grant.
  - Reset mid-burst: grant dropped; partial burst is not resumed.
- Producers must hold req_data stable while req_valid=1 and not yet accepted.

Optional Feature:
Macro ARB_STATS_EN.
- Defined: adds outputs stat_beats[15:0] and stat_stalls[15:0]. Both reset to 0 and saturate at 16'hFFFF.
  - stat_beats increments on every fifo_w_en.
  - stat_stalls increments on each BURST cycle with req_valid[owner]=1 and fifo_full=1.
- Undefined: no stat ports, no counters; all other behaviour identical.

Test Plan:
1. Reset, then req_valid=4'b0001 with data 8'hA0..A3 streamed, fifo_full=0 -> 1 idle cycle, then 4 consecutive fifo_w_en with A0,A1,A2,A3. Next cycle gnt=0 (IDLE), rr_ptr=1.
2. All four valid continuously, fifo_full=0 -> gnt sequence 0001,0010,0100,1000,0001. Each grant has 4 writes then 1 idle cycle; 20 writes in 25 cycles.
3. Owner 2 in BURST, fifo_full=1 for 3 cycles mid-burst -> fifo_w_en=0 and req_ready=0 for those 3 cycles, gnt stays 0100, beat_cnt held. Burst completes with remaining beats after full drops.
4. Owner 1 drops req_valid after 2 beats -> no write that cycle, IDLE next, rr_ptr=2. If req_valid=4'b0011, producer 0 wins the next arbitration (search from 2 wraps to 0).
5. rst asserted mid-burst (owner 3, beat_cnt=2) -> next cycle gnt=0, fifo_w_en=0, rr_ptr=0. The following arbitration with all valid grants producer 0.
6. ARB_STATS_EN defined, run scenario 3 -> stat_beats=4, stat_stalls=3. Forced 70000 writes -> stat_beats=16'hFFFF (saturates, no wrap).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ valid/ready producers.
// Optional ARB_STATS_EN adds saturating beat/stall counters (stat_beats, stat_stalls).
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               fifo_full,
  output logic               fifo_w_en,
  output logic [DW-1:0]      fifo_data,
  output logic [NREQ-1:0]    gnt
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]        stat_beats,
  output logic [15:0]        stat_stalls
`endif
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [OW-1:0] LAST_IDX  = OW'(NREQ - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   w_owner_nxt;
  logic [OW-1:0]   r_rr_ptr;
  logic [OW-1:0]   w_rr_ptr_nxt;
  logic [CW-1:0]   r_beat_cnt;
  logic [CW-1:0]   w_beat_cnt_nxt;

  logic [OW-1:0]   w_cand [NREQ];
  logic [DW-1:0]   w_slice [NREQ];
  logic [OW-1:0]   w_winner;
  logic            w_any_valid;
  logic [OW-1:0]   w_owner_inc;
  logic            w_owner_valid;
  logic            w_xfer;

  // Candidate k is the k-th index visited when searching from rr_ptr.
  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    assign w_cand[g]  = OW'((int'(r_rr_ptr) + g) % NREQ);
    assign w_slice[g] = req_data[g*DW +: DW];
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_winner    = r_rr_ptr;
    w_any_valid = 1'b0;
    // Walk from the farthest candidate down so the closest valid one wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[w_cand[k]]) begin
        w_winner    = w_cand[k];
        w_any_valid = 1'b1;
      end
    end
  end

  assign w_owner_inc   = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
  assign w_owner_valid = req_valid[r_owner];
  assign w_xfer        = (r_state == BURST) && w_owner_valid && !fifo_full;

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_any_valid) begin
          w_state_nxt    = BURST;
          w_owner_nxt    = w_winner;
          w_beat_cnt_nxt = '0;
        end
      end
      BURST: begin
        if (!w_owner_valid) begin
          w_state_nxt  = IDLE;
          w_rr_ptr_nxt = w_owner_inc;
        end else if (w_xfer) begin
          if (r_beat_cnt == LAST_BEAT) begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = w_owner_inc;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt       = '0;
    req_ready = '0;
    fifo_w_en = w_xfer;
    fifo_data = w_xfer ? w_slice[r_owner] : '0;
    for (int k = 0; k < NREQ; k++) begin
      gnt[k]       = (r_state == BURST) && (r_owner == OW'(k));
      req_ready[k] = w_xfer && (r_owner == OW'(k));
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] r_stat_beats;
  logic [15:0] r_stat_stalls;
  logic        w_stall;

  assign w_stall = (r_state == BURST) && w_owner_valid && fifo_full;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_beats  <= '0;
      r_stat_stalls <= '0;
    end else begin
      if (fifo_w_en && (r_stat_beats != 16'hFFFF))
        r_stat_beats <= r_stat_beats + 16'd1;
      if (w_stall && (r_stat_stalls != 16'hFFFF))
        r_stat_stalls <= r_stat_stalls + 16'd1;
    end
  end

  assign stat_beats  = r_stat_beats;
  assign stat_stalls = r_stat_stalls;
`endif

endmodule
